updown_counter_ctrl: RTL and testbench

Command-driven sequencer for an N-bit up/down counter.
- Accepts a counting job over a valid/ready handshake. Job fields: mode, lower bound, upper bound, pass count.
- Runs the counter between the bounds (up, down or ping-pong), then reports completion.
- Sits between system control logic and the counter datapath.
- The counter never wraps; it only moves inside the commanded range.

---
 rtl/updown_counter_ctrl_pkg.sv | 25 ++
 rtl/updown_counter_ctrl_if.sv | 27 ++
 rtl/updown_counter_ctrl_core.sv | 33 +++
 rtl/updown_counter_ctrl.sv | 144 ++++++++++++++
 tb/tb_updown_counter_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/updown_counter_ctrl_pkg.sv
// updown_ctrl_pkg: shared encodings for the up/down counter sequencer.
// Rev 1.0
`default_nettype none

package updown_ctrl_pkg;

  localparam int MODE_W = 2;
  localparam int STATE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_ILLEGAL  = 2'b11
  } mode_e;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/updown_counter_ctrl_if.sv
// updown_counter_ctrl_if: job command channel (valid/ready plus job fields).
// Rev 1.0
`default_nettype none

interface updown_counter_ctrl_if #(
  parameter int WIDTH  = 3,
  parameter int PASS_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_mode;
  logic [WIDTH-1:0]  cmd_lo;
  logic [WIDTH-1:0]  cmd_hi;
  logic [PASS_W-1:0] cmd_passes;

  modport master (
    output cmd_valid, cmd_mode, cmd_lo, cmd_hi, cmd_passes,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_lo, cmd_hi, cmd_passes,
    output cmd_ready
  );
endinterface

`default_nettype wire

// File: rtl/updown_counter_ctrl_core.sv
// counter_nbit_ud_core: WIDTH-bit loadable up/down counter register.
// Rev 1.0
`default_nettype none

module counter_nbit_ud_core #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_en) begin
      r_q <= i_up ? r_q + 1'b1 : r_q - 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/updown_counter_ctrl.sv
// updown_counter_ctrl: accepts counting jobs and sequences the counter core.
// Rev 1.0
`default_nettype none

module updown_counter_ctrl
  import updown_ctrl_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int PASS_W = 4
) (
  input  logic                      clock,
  input  logic                      resetn,
  updown_counter_ctrl_if.slave      cmd,
  input  logic                      pause,
  input  logic                      abort,
  output logic [WIDTH-1:0]          Q,
  output logic                      dir_up,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  state_e            r_state, w_state_nxt;
  logic              r_dir, w_dir_nxt;
  logic [PASS_W-1:0] r_rem, w_rem_nxt;
  logic [WIDTH-1:0]  r_lo, w_lo_nxt;
  logic [WIDTH-1:0]  r_hi, w_hi_nxt;
  logic              r_err, w_err_nxt;

  logic              w_load;
  logic [WIDTH-1:0]  w_load_val;
  logic              w_en;
  logic              w_up;
  logic [WIDTH-1:0]  w_q;
  logic              w_at_end;
  logic              w_illegal;
  mode_e             w_mode;

  counter_nbit_ud_core #(.WIDTH(WIDTH)) u_core (
    .clock      (clock),
    .resetn     (resetn),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_en),
    .i_up       (w_up),
    .o_q        (w_q)
  );

  assign w_mode    = mode_e'(cmd.cmd_mode);
  assign w_illegal = (w_mode == MODE_ILLEGAL) || (cmd.cmd_lo > cmd.cmd_hi) ||
                     ((w_mode == MODE_PINGPONG) && (cmd.cmd_passes == '0));
  // Endpoint is checked before any step so the counter can never wrap.
  assign w_at_end  = r_dir ? (w_q == r_hi) : (w_q == r_lo);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_dir   <= 1'b1;
      r_rem   <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_rem   <= w_rem_nxt;
      r_lo    <= w_lo_nxt;
      r_hi    <= w_hi_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_rem_nxt   = r_rem;
    w_lo_nxt    = r_lo;
    w_hi_nxt    = r_hi;
    w_err_nxt   = 1'b0;
    w_load      = 1'b0;
    w_load_val  = w_q;
    w_en        = 1'b0;
    w_up        = r_dir;

    case (r_state)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          if (w_illegal) begin
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
            w_lo_nxt    = cmd.cmd_lo;
            w_hi_nxt    = cmd.cmd_hi;
            w_load      = 1'b1;
            if (w_mode == MODE_DOWN) begin
              w_load_val = cmd.cmd_hi;
              w_dir_nxt  = 1'b0;
              w_rem_nxt  = PASS_W'(1);
            end else begin
              w_load_val = cmd.cmd_lo;
              w_dir_nxt  = 1'b1;
              w_rem_nxt  = (w_mode == MODE_PINGPONG) ? cmd.cmd_passes : PASS_W'(1);
            end
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (!pause) begin
          if (w_at_end) begin
            if (r_rem == PASS_W'(1)) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_rem_nxt = r_rem - 1'b1;
              w_dir_nxt = ~r_dir;
              // A degenerate range turns around in place without moving.
              w_en      = (r_lo != r_hi);
              w_up      = ~r_dir;
            end
          end else begin
            w_en = 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign cmd.cmd_ready = (r_state == ST_IDLE);
  assign busy          = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign done          = (r_state == ST_DONE);
  assign err           = r_err;
  assign Q             = w_q;
  assign dir_up        = r_dir;

endmodule

`default_nettype wire

// File: tb/tb_updown_counter_ctrl.sv
// tb_updown_counter_ctrl: directed per-edge vector table plus reset sequences.
// Rev 1.0
`default_nettype none

module tb_updown_counter_ctrl;

  logic       clock;
  logic       resetn;
  logic       pause;
  logic       abort;
  logic [2:0] Q;
  logic       dir_up;
  logic       busy;
  logic       done;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  updown_counter_ctrl_if #(.WIDTH(3), .PASS_W(4)) cmd_if ();

  updown_counter_ctrl #(.WIDTH(3), .PASS_W(4)) dut (
    .clock  (clock),
    .resetn (resetn),
    .cmd    (cmd_if.slave),
    .pause  (pause),
    .abort  (abort),
    .Q      (Q),
    .dir_up (dir_up),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       v;
    logic [1:0] m;
    logic [2:0] lo;
    logic [2:0] hi;
    logic [3:0] ps;
    logic       pa;
    logic       ab;
    logic [2:0] q;
    logic       dir;
    logic       bsy;
    logic       dn;
    logic       er;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic v, input logic [1:0] m, input logic [2:0] lo,
                              input logic [2:0] hi, input logic [3:0] ps, input logic pa,
                              input logic ab, input logic [2:0] q, input logic dir,
                              input logic bsy, input logic dn, input logic er);
    vec_t t;
    t.v = v; t.m = m; t.lo = lo; t.hi = hi; t.ps = ps; t.pa = pa; t.ab = ab;
    t.q = q; t.dir = dir; t.bsy = bsy; t.dn = dn; t.er = er;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] q, input logic dir,
                           input logic bsy, input logic dn, input logic er);
    check({tag, ".Q"}, int'(Q), int'(q));
    check({tag, ".dir_up"}, int'(dir_up), int'(dir));
    check({tag, ".busy"}, int'(busy), int'(bsy));
    check({tag, ".done"}, int'(done), int'(dn));
    check({tag, ".err"}, int'(err), int'(er));
    check({tag, ".cmd_ready"}, int'(cmd_if.cmd_ready), int'(!bsy));
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [2:0] lo,
                       input logic [2:0] hi, input logic [3:0] ps, input logic pa,
                       input logic ab);
    cmd_if.cmd_valid  = v;
    cmd_if.cmd_mode   = m;
    cmd_if.cmd_lo     = lo;
    cmd_if.cmd_hi     = hi;
    cmd_if.cmd_passes = ps;
    pause = pa;
    abort = ab;
  endtask

  initial begin
    resetn = 1'b0;
    drive(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0);

    // Each row: inputs seen at one rising edge, expected outputs just after it.
    // UP 2..5
    add(1, 2'd0, 3'd2, 3'd5, 4'd0, 0, 0, 3'd2, 1, 1, 0, 0);
    add(0, 2'd0, 3'd7, 3'd0, 4'd0, 0, 0, 3'd3, 1, 1, 0, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd4, 1, 1, 0, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd5, 1, 1, 0, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd5, 1, 1, 1, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd5, 1, 0, 0, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd5, 1, 0, 0, 0);
    // DOWN 0..7, full range
    add(1, 2'd1, 3'd0, 3'd7, 4'd0, 0, 0, 3'd7, 0, 1, 0, 0);
    for (int i = 6; i >= 0; i--) add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'(i), 0, 1, 0, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd0, 0, 1, 1, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd0, 0, 0, 0, 0);
    // PINGPONG 1..3, 3 passes; a command offered mid-run is ignored
    add(1, 2'd2, 3'd1, 3'd3, 4'd3, 0, 0, 3'd1, 1, 1, 0, 0);
    add(1, 2'd0, 3'd0, 3'd7, 4'd0, 0, 0, 3'd2, 1, 1, 0, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd3, 1, 1, 0, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd2, 0, 1, 0, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd1, 0, 1, 0, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd2, 1, 1, 0, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd3, 1, 1, 0, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd3, 1, 1, 1, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd3, 1, 0, 0, 0);
    // UP 0..7 with a 2-cycle pause at 3 and abort at 4
    add(1, 2'd0, 3'd0, 3'd7, 4'd0, 0, 0, 3'd0, 1, 1, 0, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd1, 1, 1, 0, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd2, 1, 1, 0, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd3, 1, 1, 0, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 1, 0, 3'd3, 1, 1, 0, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 1, 0, 3'd3, 1, 1, 0, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd4, 1, 1, 0, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 1, 3'd4, 1, 0, 0, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd4, 1, 0, 0, 0);
    // abort beats pause; abort in IDLE does nothing
    add(1, 2'd0, 3'd0, 3'd7, 4'd0, 0, 0, 3'd0, 1, 1, 0, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 1, 1, 3'd0, 1, 0, 0, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 1, 3'd0, 1, 0, 0, 0);
    // rejected commands: lo>hi, illegal mode, PINGPONG with zero passes
    add(1, 2'd0, 3'd5, 3'd2, 4'd0, 0, 0, 3'd0, 1, 0, 0, 1);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd0, 1, 0, 0, 0);
    add(1, 2'd3, 3'd1, 3'd2, 4'd1, 0, 0, 3'd0, 1, 0, 0, 1);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd0, 1, 0, 0, 0);
    add(1, 2'd2, 3'd1, 3'd2, 4'd0, 0, 0, 3'd0, 1, 0, 0, 1);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd0, 1, 0, 0, 0);
    // UP lo=hi=6
    add(1, 2'd0, 3'd6, 3'd6, 4'd0, 0, 0, 3'd6, 1, 1, 0, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd6, 1, 1, 1, 0);
    add(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0, 3'd6, 1, 0, 0, 0);

    #20;
    check_all("reset", 3'd0, 1, 0, 0, 0);
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      drive(vecs[i].v, vecs[i].m, vecs[i].lo, vecs[i].hi, vecs[i].ps, vecs[i].pa, vecs[i].ab);
      @(posedge clock);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].dir, vecs[i].bsy, vecs[i].dn, vecs[i].er);
    end

    // Asynchronous reset in the middle of a DOWN job
    @(negedge clock);
    drive(1, 2'd1, 3'd1, 3'd6, 4'd0, 0, 0);
    @(negedge clock);
    drive(0, 2'd0, 3'd0, 3'd0, 4'd0, 0, 0);
    @(posedge clock);
    #2;
    check_all("prerst", 3'd5, 0, 1, 0, 0);
    resetn = 1'b0;
    #1;
    check_all("midrst", 3'd0, 1, 0, 0, 0);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    check_all("postrst", 3'd0, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
